mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter slave on the picorv32 native memory bus, downstream of the processor alongside the main Memory.
- Decodes its own 16-byte address window, returns its own ready, and buffers outgoing bytes in a 4-entry FIFO.
- Serialises the buffered bytes as 8N1 frames on uart_tx.
- Gives firmware console output without a full SoC interconnect.

Parameters:
- BASE_ADDR, 32'h0000_1000: byte address of the register window; must be 16-byte aligned.
- DEFAULT_DIV, 16'd104: reset value of DIVISOR, in clk cycles per serial bit.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- mem_valid  input  1  processor bus request valid
- mem_addr  input  32  byte address
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte write strobes; all zero means read
- mem_ready  output  1  registered transfer-complete pulse for this slave
- mem_rdata  output  32  read data; valid while mem_ready=1, 0 otherwise
- uart_tx  output  1  serial output; idles high

Behaviour:
- Reset: one clock, asynchronous active-low reset. All outputs and internal state clear immediately when reset_n falls.
  - mem_ready=0, mem_rdata=0, uart_tx=1.
  - FIFO empty, transmit FSM in IDLE, DIVISOR=DEFAULT_DIV.
- Window decode: hit = mem_valid & (mem_addr[31:4]==BASE_ADDR[31:4]). Register select is mem_addr[3:2]. Outside the window the block does nothing and mem_ready stays 0.
- Handshake:
  - At an edge where hit & ~mem_ready is sampled, the access executes and mem_ready=1 for exactly one cycle. Latency is 1 cycle.
  - mem_ready never asserts on two consecutive cycles.
  - mem_rdata is registered on the same edge and returns to 0 when mem_ready deasserts.
- Registers:
  - 0x0 TXDATA: a write with mem_wstrb[0]=1 pushes mem_wdata[7:0]. If the FIFO is full, mem_ready is withheld (stall) until the first edge at which an entry is free; push and ready then occur together. Reads return 0. A write with mem_wstrb[0]=0 is acknowledged with no push.
  - 0x4 STATUS (read-only): bit0=busy (FSM not IDLE), bit1=fifo_full, bit2=fifo_empty, bits[6:4]=fifo level 0..4, all other bits 0. Writes are acknowledged and ignored.
  - 0x8 DIVISOR (rw, bits[15:0]): mem_wstrb[0] writes bits[7:0], mem_wstrb[1] writes bits[15:8]. A resulting value of 0 is stored as 1. Reads are zero-extended. A new value takes effect at the next bit boundary.
  - 0xC: reads 0, writes ignored, still acknowledged.
- Transmit FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and enter START on the same edge.
  - Each bit lasts DIVISOR clk cycles, counted by a baud counter.
  - START drives 0. DATA drives 8 bits LSB first, using a 3-bit bit counter. STOP drives 1.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
  - Frame length is 10*DIVISOR cycles.
- FIFO: circular buffer with a wrap-around pointer and a level count of 0..FIFO_DEPTH.
  - A push and a pop on the same edge leave the level unchanged.
  - A push to a full FIFO coinciding with a pop is accepted on that edge: the stall releases.
- Reset mid-frame: uart_tx returns to 1 immediately. The frame is abandoned and the FIFO contents are lost.
- A mem_valid drop during a stall cancels the access with no push. picorv32 never does this; it is handled for robustness only.

Test Plan:
- Reset with no traffic -> uart_tx=1, mem_ready=0; a read of 0x4 returns 32'h0000_0004 (empty) and a read of 0x8 returns 104; each read gives mem_ready one cycle after mem_valid.
- DIVISOR=4, write 0x55 to TXDATA -> START begins within 2 cycles; uart_tx carries 0 then 1,0,1,0,1,0,1,0 then 1, each bit 4 cycles (40-cycle frame); STATUS bit0=1 during the frame, then 0.
- DIVISOR=4, six back-to-back TXDATA writes of 0x01..0x06 -> the first byte is popped immediately; writes 2-5 fill the FIFO (STATUS bit1=1, level=4); the sixth write stalls until the first frame ends, then acknowledges; bytes appear in order with no inter-frame gap.
- Write 0 to DIVISOR, then read it back -> 1; wstrb=4'b0010 with wdata=0x0000_AB00 sets the upper byte only.
- Access to BASE_ADDR+0x10 and BASE_ADDR-4 -> mem_ready never asserts; access to 0xC -> acknowledged, rdata=0.
- Assert reset_n=0 mid-DATA with 3 bytes queued -> uart_tx=1 in the same cycle; after release, STATUS shows empty and no further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
// Holds a 16-byte register window, a TX FIFO and a START/DATA/STOP serialiser.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [15:0] DEFAULT_DIV = 16'd104,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_ready;
  logic [31:0] r_rdata;

  logic        w_hit;
  logic        w_acc;
  logic [1:0]  w_sel;
  logic        w_wr;
  logic        w_empty;
  logic        w_full;
  logic        w_txwr;
  logic        w_push;
  logic        w_pop;
  logic        w_ack;
  logic        w_bit_end;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_bitcnt_nxt;
  logic [7:0]  w_shift_nxt;
  logic        w_tx_nxt;
  logic [31:0] w_status;
  logic [31:0] w_rd;
  logic [15:0] w_div_new;

  assign w_hit     = mem_valid & (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_acc     = w_hit & ~r_ready;
  assign w_sel     = mem_addr[3:2];
  assign w_wr      = |mem_wstrb;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LVL);
  assign w_bit_end = (r_cnt == '0);

  // A TXDATA write to a full FIFO is held off unless the serialiser pops on the same edge.
  assign w_txwr = w_acc & (w_sel == 2'd0) & mem_wstrb[0];
  assign w_push = w_txwr & (~w_full | w_pop);
  assign w_ack  = w_acc & ~(w_txwr & ~w_push);

  assign w_div_new = {mem_wstrb[1] ? mem_wdata[15:8] : r_div[15:8],
                      mem_wstrb[0] ? mem_wdata[7:0]  : r_div[7:0]};

  always_comb begin
    w_status         = '0;
    w_status[0]      = (r_state != S_IDLE);
    w_status[1]      = w_full;
    w_status[2]      = w_empty;
    w_status[4 +: LW] = r_level;
    case (w_sel)
      2'd1:    w_rd = w_status;
      2'd2:    w_rd = {16'h0000, r_div};
      default: w_rd = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_tx_nxt     = r_tx;
    w_cnt_nxt    = w_bit_end ? (r_div - 16'd1) : (r_cnt - 16'd1);
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = r_div - 16'd1;
        w_tx_nxt  = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rptr];
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_tx_nxt     = r_shift[0];
          w_bitcnt_nxt = '0;
          w_state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bitcnt == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_tx_nxt     = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rptr];
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= mem_wdata[7:0];
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_div   <= DEFAULT_DIV;
    end else begin
      r_ready <= w_ack;
      r_rdata <= (w_ack & ~w_wr) ? w_rd : '0;
      if (w_ack && (w_sel == 2'd2) && (mem_wstrb[1:0] != 2'b00)) begin
        r_div <= (w_div_new == 16'h0000) ? 16'd1 : w_div_new;
      end
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign uart_tx   = r_tx;

endmodule
